rr_mux_arb: RTL
===============

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, width of each channel's data word (legal 1..64).
REQ-003 SHALL derive CH_W = max(1, ceil(log2(NUM_CH))), width of the channel index.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  NUM_CH*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_valid  input  NUM_CH  per-channel request; bit i means channel i holds a word.
REQ-008 SHALL have port in_ready  output  NUM_CH  per-channel grant, combinational, at most one bit set.
REQ-009 SHALL have port prio_mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-010 SHALL have port out_data  output  DATA_W  registered selected word.
REQ-011 SHALL have port out_ch  output  CH_W  registered index of the channel that supplied out_data.
REQ-012 SHALL have port out_valid  output  1  registered; out_data and out_ch are meaningful.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the output word when high with out_valid.

Function
REQ-014 SHALL define load = !out_valid || out_ready.
REQ-015 SHALL transfer channel i in a cycle exactly when in_valid[i] && in_ready[i].
REQ-016 SHALL drive in_ready all zero whenever load is 0 or rst is 1.
REQ-017 SHALL, when load is 1 and any in_valid bit is set, raise exactly one in_ready bit, for the granted channel g.
REQ-018 SHALL, on a transfer from g, load out_data = in_data[g], out_ch = g and out_valid = 1 at the next edge (1-cycle latency).
REQ-019 SHALL, when load is 1 and in_valid is all zero, clear out_valid at the next edge and hold out_data and out_ch.
REQ-020 SHALL hold out_data, out_ch and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL sustain one transfer per cycle while out_ready is held at 1 and requests are present.
REQ-022 SHALL, in round-robin mode, search channels ptr, ptr+1, ..., wrapping from NUM_CH-1 to 0, and grant the first valid channel.
REQ-023 SHALL update ptr to (g+1) mod NUM_CH after each round-robin transfer; ptr is unchanged when there is no transfer.
REQ-024 SHALL, in fixed mode, grant the lowest-index valid channel and leave ptr unchanged.
REQ-025 SHALL apply a prio_mode change combinationally to the grant decision in the same cycle; ptr retains its value across mode changes.
REQ-026 SHALL ignore in_data of channels that are not granted and in_valid of channels while load is 0.

Reset
REQ-027 SHALL set, at an edge with rst = 1, out_valid = 0, out_data = 0, out_ch = 0 and ptr = 0.
REQ-028 SHALL discard a held, unaccepted output word when rst asserts mid-operation, with no transfer in the rst cycle.
REQ-029 SHALL make the first grant after reset deassertion start its round-robin search at channel 0.

Verification (NUM_CH=4, DATA_W=8)
REQ-030 SHALL cover reset: rst=1 for 2 cycles with in_valid=1111 and out_ready=1 -> in_ready=0000; afterwards out_valid=0, out_data=0x00 and out_ch=0.
REQ-031 SHALL cover a single request: in_valid=0100, ch2 data=0xA5, out_ready=1 -> in_ready=0100 in the same cycle; next cycle out_valid=1, out_data=0xA5, out_ch=2.
REQ-032 SHALL cover round-robin fairness: prio_mode=0, in_valid=1111 held, ch i data=0x10+i, out_ready=1 -> out_ch sequence is 0,1,2,3,0 and out_data is 0x10,0x11,0x12,0x13,0x10.
REQ-033 SHALL cover wrap-around: the last grant was ch2 (ptr=3) and in_valid=0011 -> ch0 is granted, then ch1.
REQ-034 SHALL cover backpressure: out_valid=1 and out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000 and out_data/out_ch stay stable; with out_ready=1 the next channel in round-robin order follows.
REQ-035 SHALL cover fixed mode and reset mid-operation: prio_mode=1 and in_valid=1111 -> out_ch=0 every cycle, and in_valid=1110 -> out_ch=1; rst while out_valid=1 and out_ready=0 -> out_valid=0 at the next edge.

Source files
------------

// File: rtl/rr_mux_arb.sv
// rr_mux_arb -- N-channel request/grant multiplexer with a registered output.
//
// Each cycle the arbiter picks one requesting channel (round-robin or fixed
// priority), forwards its word into a single output register, and reports
// the grant on in_ready. The output register behaves as a one-deep pipeline
// stage with valid/ready handshaking.
//
// Ports
//   clk        in   1              clock, all state changes on rising edge
//   rst        in   1              synchronous active-high reset
//   in_data    in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//   in_valid   in   NUM_CH         per-channel request
//   in_ready   out  NUM_CH         per-channel grant (combinational, one-hot or zero)
//   prio_mode  in   1              0 = round-robin, 1 = fixed priority (ch0 highest)
//   out_data   out  DATA_W         registered selected word
//   out_ch     out  CH_W           registered source channel of out_data
//   out_valid  out  1              registered output valid
//   out_ready  in   1              downstream accepts the output word
module rr_mux_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     prio_mode,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] ch_data [NUM_CH];

  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic              out_valid_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;

  logic              load;
  logic              grant_any;
  logic [CH_W-1:0]   grant_idx;
  logic              xfer;

  int                start_idx;
  int                cand;
  logic [CH_W-1:0]   cand_ch;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The output register can take a new word when it is empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Search NUM_CH candidates starting at ptr (round-robin) or at 0 (fixed),
  // wrapping modulo NUM_CH; the first requesting candidate wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_ch   = '0;
    start_idx = prio_mode ? 0 : int'(ptr_q);
    for (int k = 0; k < NUM_CH; k++) begin
      cand = start_idx + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_ch = CH_W'(cand);
      if (!grant_any && in_valid[cand_ch]) begin
        grant_any = 1'b1;
        grant_idx = cand_ch;
      end
    end
  end

  // A transfer happens only when the output stage can load and we are not in reset.
  assign xfer = load && !rst && grant_any;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = xfer && (grant_idx == CH_W'(gi));
    end
  endgenerate

  // Pointer moves just past the winner so it becomes lowest priority next time.
  assign ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_data_q  <= ch_data[grant_idx];
        out_ch_q    <= grant_idx;
        out_valid_q <= 1'b1;
        if (!prio_mode) begin
          ptr_q <= ptr_d;
        end
      end else begin
        // Nothing to forward: drop valid but keep the last word and channel.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
